// File: rtl/adrv9009_tx_pkg.sv
// adrv9009_tx_pkg
// Shared definitions for the transmit FIR interpolator: data/coefficient
// widths, control-field encodings, FSM state codes and helper functions
// that map the control fields onto phase length, interpolation shift and
// output scaling.
package adrv9009_tx_pkg;

  localparam int DW       = 16;
  localparam int CW       = 16;
  localparam int MAX_TAPS = 48;
  localparam int ADDR_W   = 6;
  localparam int ACC_W    = 40;

  // mode_tfir: only 01 selects the short filter, every other code is 48 taps
  localparam logic [1:0] MODE_24 = 2'b01;

  // interp_tfir: 10 and 11 both mean x4
  localparam logic [1:0] INTERP_X1 = 2'b00;
  localparam logic [1:0] INTERP_X2 = 2'b01;

  localparam logic [1:0] GAIN_0DB  = 2'b00;
  localparam logic [1:0] GAIN_P6DB = 2'b01;
  localparam logic [1:0] GAIN_M6DB = 2'b10;

  // Right-shift applied to the Q1.15 x Q1.15 accumulator per gain setting
  localparam logic [4:0] SHIFT_0DB  = 5'd15;
  localparam logic [4:0] SHIFT_P6DB = 5'd14;
  localparam logic [4:0] SHIFT_M6DB = 5'd16;
  localparam logic [4:0] SHIFT_M12DB = 5'd17;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_RND  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

  // log2 of the interpolation factor L
  function automatic logic [1:0] interp_shift(input logic [1:0] interp);
    case (interp)
      INTERP_X1: interp_shift = 2'd0;
      INTERP_X2: interp_shift = 2'd1;
      default:   interp_shift = 2'd2;
    endcase
  endfunction

  // Taps per polyphase branch, M = N / L
  function automatic logic [ADDR_W-1:0] phase_len(input logic taps24,
                                                  input logic [1:0] lsh);
    logic [ADDR_W-1:0] n;
    n = taps24 ? ADDR_W'(24) : ADDR_W'(48);
    phase_len = n >> lsh;
  endfunction

  function automatic logic [4:0] gain_shift(input logic [1:0] gain);
    case (gain)
      GAIN_0DB:  gain_shift = SHIFT_0DB;
      GAIN_P6DB: gain_shift = SHIFT_P6DB;
      GAIN_M6DB: gain_shift = SHIFT_M6DB;
      default:   gain_shift = SHIFT_M12DB;
    endcase
  endfunction

  // Round half up, arithmetic shift, then clamp to the signed DW range
  function automatic logic signed [DW-1:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                     input logic [4:0] sh);
    logic signed [ACC_W-1:0] bias;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] clamped;
    bias    = ACC_W'(1) <<< (sh - 5'd1);
    sum     = acc + bias;
    shifted = sum >>> sh;
    if (shifted > SAT_MAX)      clamped = SAT_MAX;
    else if (shifted < SAT_MIN) clamped = SAT_MIN;
    else                        clamped = shifted;
    round_sat = clamped[DW-1:0];
  endfunction

endpackage

// File: rtl/adrv9009_tfir_interp_if.sv
// adrv9009_tfir_interp_if
// Sample streaming bundle for the TX FIR interpolator.
//   in / in_valid / in_ready    : low-rate input samples toward the filter
//   out / out_valid / out_ready : interpolated samples toward the DAC side
// master = sample source/sink around the filter, slave = the filter itself.
interface adrv9009_tfir_interp_if;
  logic signed [adrv9009_tx_pkg::DW-1:0] in;
  logic                                  in_valid;
  logic                                  in_ready;
  logic signed [adrv9009_tx_pkg::DW-1:0] out;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/adrv9009_tfir_coeff_ram.sv
// adrv9009_tfir_coeff_ram
// MAX_TAPS x CW coefficient store, synchronous write, asynchronous read.
// Not reset: coefficients survive a reset of the filter datapath.
// Ports:
//   clk_m   : clock
//   wr_en   : write strobe, already qualified by the parent
//   wr_addr : write index
//   wr_data : coefficient to store
//   rd_addr : read index for the MAC engine
//   rd_data : coefficient at rd_addr (combinational)
module adrv9009_tfir_coeff_ram
  import adrv9009_tx_pkg::*;
(
  input  logic                     clk_m,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [CW-1:0]     wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [CW-1:0]     rd_data
);

  logic signed [CW-1:0] mem_q [MAX_TAPS];
  logic signed [CW-1:0] mem_d [MAX_TAPS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_addr < ADDR_W'(MAX_TAPS))) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk_m) begin
    mem_q <= mem_d;
  end

  // Out-of-range reads return zero rather than an undefined entry
  assign rd_data = (rd_addr < ADDR_W'(MAX_TAPS)) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/adrv9009_tfir_interp.sv
// adrv9009_tfir_interp
// Transmit polyphase FIR interpolator (x1/x2/x4, 24 or 48 taps) with a
// single time-multiplexed MAC, gain, rounding and saturation, plus a
// registered bypass path when the filter is disabled.
// Ports:
//   clk_m       : processing clock
//   reset       : synchronous, active-high
//   io          : sample stream (slave side), see adrv9009_tfir_interp_if
//   en_tfir     : 1 = filter, 0 = bypass (coefficient writes allowed)
//   mode_tfir   : 01 = 24 taps, otherwise 48
//   interp_tfir : 00 = x1, 01 = x2, 1x = x4
//   gain_tfir   : 00 = 0 dB, 01 = +6 dB, 10 = -6 dB, 11 = -12 dB
//   wr_en/addr_in/coeff_in : coefficient write port
module adrv9009_tfir_interp
  import adrv9009_tx_pkg::*;
(
  input  logic                 clk_m,
  input  logic                 reset,
  adrv9009_tfir_interp_if.slave io,
  input  logic                 en_tfir,
  input  logic [1:0]           mode_tfir,
  input  logic [1:0]           interp_tfir,
  input  logic [1:0]           gain_tfir,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic signed [CW-1:0] coeff_in
);

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       k_q, k_d;
  logic [1:0]              p_q, p_d;
  logic [ADDR_W-1:0]       m_q, m_d;
  logic [1:0]              lsh_q, lsh_d;
  logic [1:0]              gain_q, gain_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DW-1:0]    out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    en_q, en_d;
  logic signed [DW-1:0]    hist_q [MAX_TAPS];
  logic signed [DW-1:0]    hist_d [MAX_TAPS];

  logic                    en_rise;
  logic                    in_ready_c;
  logic                    accept;
  logic                    ram_we;
  logic [ADDR_W-1:0]       coef_addr;
  logic signed [CW-1:0]    coef_rd;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_base;
  logic [2:0]              last_phase;

  assign en_rise = en_tfir && !en_q;

  // Coefficients may only change while the filter is not using them
  assign ram_we = wr_en && !en_tfir && (addr_in < ADDR_W'(MAX_TAPS));

  // Polyphase index h[k*L + p]; p < L so the sum never carries past N-1
  assign coef_addr = (k_q << lsh_q) + ADDR_W'(p_q);

  adrv9009_tfir_coeff_ram u_coeff_ram (
    .clk_m   (clk_m),
    .wr_en   (ram_we),
    .wr_addr (addr_in),
    .wr_data (coeff_in),
    .rd_addr (coef_addr),
    .rd_data (coef_rd)
  );

  // Bypass accepts whenever the output register is free or draining; the
  // filter only accepts in IDLE, and never in the cycle that clears history.
  always_comb begin
    if (reset)         in_ready_c = 1'b0;
    else if (!en_tfir) in_ready_c = !out_valid_q || io.out_ready;
    else               in_ready_c = !en_rise && (state_q == ST_IDLE) &&
                                    (!out_valid_q || io.out_ready);
  end

  assign accept       = io.in_valid && in_ready_c;
  assign io.in_ready  = in_ready_c;
  assign io.out       = out_q;
  assign io.out_valid = out_valid_q;

  always_comb begin
    prod       = coef_rd * hist_q[k_q];
    acc_base   = (k_q == '0) ? '0 : acc_q;
    last_phase = (3'd1 << lsh_q) - 3'd1;
  end

  // Main control: bypass register, history clear on enable, and the
  // IDLE -> MAC (M cycles) -> RND -> OUT loop repeated once per phase.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    p_d         = p_q;
    m_d         = m_q;
    lsh_d       = lsh_q;
    gain_d      = gain_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    hist_d      = hist_q;
    en_d        = en_tfir;

    if (!en_tfir) begin
      state_d = ST_IDLE;
      if (io.out_ready) out_valid_d = 1'b0;
      if (accept) begin
        out_d       = io.in;
        out_valid_d = 1'b1;
      end
    end else if (en_rise) begin
      state_d = ST_IDLE;
      hist_d  = '{default: '0};
      if (io.out_ready) out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.out_ready) out_valid_d = 1'b0;
          if (accept) begin
            hist_d[0] = io.in;
            for (int i = 1; i < MAX_TAPS; i++) hist_d[i] = hist_q[i-1];
            lsh_d   = interp_shift(interp_tfir);
            m_d     = phase_len(mode_tfir == MODE_24, interp_shift(interp_tfir));
            gain_d  = gain_tfir;
            p_d     = 2'd0;
            k_d     = '0;
            state_d = ST_MAC;
          end
        end
        ST_MAC: begin
          acc_d = acc_base + $signed({{(ACC_W-2*DW){prod[2*DW-1]}}, prod});
          if (k_q == m_q - ADDR_W'(1)) state_d = ST_RND;
          else                         k_d     = k_q + ADDR_W'(1);
        end
        ST_RND: begin
          out_d       = round_sat(acc_q, gain_shift(gain_q));
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end
        ST_OUT: begin
          if (io.out_ready) begin
            out_valid_d = 1'b0;
            if ({1'b0, p_q} < last_phase) begin
              p_d     = p_q + 2'd1;
              k_d     = '0;
              state_d = ST_MAC;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_m) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      p_q         <= '0;
      m_q         <= '0;
      lsh_q       <= '0;
      gain_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      en_q        <= 1'b0;
      hist_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      p_q         <= p_d;
      m_q         <= m_d;
      lsh_q       <= lsh_d;
      gain_q      <= gain_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      en_q        <= en_d;
      hist_q      <= hist_d;
    end
  end

endmodule

// File: tb/tb_adrv9009_tfir_interp.sv
// tb_adrv9009_tfir_interp
// Directed bench for the TX FIR interpolator: reset, bypass, impulse
// response, write protection, backpressure, reset during MAC, control
// change mid-sample and saturation. Expected values are hand computed
// from h[i] = i+1 (or 0x7FFF) and the rounding rule.
module tb_adrv9009_tfir_interp;
  import adrv9009_tx_pkg::*;

  logic                 clk_m;
  logic                 reset;
  logic                 en_tfir;
  logic [1:0]           mode_tfir;
  logic [1:0]           interp_tfir;
  logic [1:0]           gain_tfir;
  logic                 wr_en;
  logic [ADDR_W-1:0]    addr_in;
  logic signed [CW-1:0] coeff_in;

  int errors   = 0;
  int checks   = 0;
  int last_lat = 0;

  adrv9009_tfir_interp_if io ();

  adrv9009_tfir_interp dut (
    .clk_m       (clk_m),
    .reset       (reset),
    .io          (io),
    .en_tfir     (en_tfir),
    .mode_tfir   (mode_tfir),
    .interp_tfir (interp_tfir),
    .gain_tfir   (gain_tfir),
    .wr_en       (wr_en),
    .addr_in     (addr_in),
    .coeff_in    (coeff_in)
  );

  initial begin
    clk_m = 1'b0;
    forever #5 clk_m = ~clk_m;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_coeff(input int a, input int v);
    @(negedge clk_m);
    wr_en    = 1'b1;
    addr_in  = ADDR_W'(a);
    coeff_in = CW'(v);
    @(negedge clk_m);
    wr_en    = 1'b0;
  endtask

  // Present one sample and hold it until the DUT takes it (bounded)
  task automatic applyStimulus(input int v);
    int n;
    @(negedge clk_m);
    io.in       = DW'(v);
    io.in_valid = 1'b1;
    #1;
    n = 0;
    while (!io.in_ready && n < 500) begin
      @(negedge clk_m);
      #1;
      n++;
    end
    check("accept", 32'(io.in_ready), 1);
    @(posedge clk_m);
    #1;
    io.in_valid = 1'b0;
  endtask

  // last_lat = index of the first falling edge with out_valid high,
  // counting the falling edge right after the previous handshake as 1
  task automatic wait_valid(input string tag);
    int n;
    n = 1;
    @(negedge clk_m);
    while (!io.out_valid && n < 500) begin
      @(negedge clk_m);
      n++;
    end
    last_lat = n;
    check({tag, "_valid"}, 32'(io.out_valid), 1);
  endtask

  task automatic checkOutput(input string tag, input int exp);
    wait_valid(tag);
    check(tag, 32'(io.out), exp);
    @(posedge clk_m);
    #1;
  endtask

  task automatic drain_output(input string tag);
    wait_valid(tag);
    @(posedge clk_m);
    #1;
  endtask

  // A low-then-high pulse on en_tfir clears the history
  task automatic restart_filter();
    @(negedge clk_m);
    en_tfir = 1'b0;
    @(negedge clk_m);
    en_tfir = 1'b1;
  endtask

  initial begin
    int stable;
    reset        = 1'b1;
    en_tfir      = 1'b0;
    mode_tfir    = 2'b01;
    interp_tfir  = 2'b01;
    gain_tfir    = 2'b00;
    wr_en        = 1'b0;
    addr_in      = '0;
    coeff_in     = '0;
    io.in        = '0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;

    repeat (3) @(negedge clk_m);
    check("rst_out", 32'(io.out), 0);
    check("rst_out_valid", 32'(io.out_valid), 0);
    check("rst_in_ready", 32'(io.in_ready), 0);
    reset = 1'b0;

    for (int i = 0; i < MAX_TAPS; i++) write_coeff(i, i + 1);

    $display("[TB] bypass");
    applyStimulus(1234);
    checkOutput("byp_out", 1234);
    check("byp_latency", last_lat, 1);

    $display("[TB] impulse 24 taps x2 0dB");
    @(negedge clk_m);
    en_tfir = 1'b1;
    applyStimulus(32767);
    checkOutput("imp_p0", 1);
    check("imp_latency", last_lat, 14);
    checkOutput("imp_p1", 2);
    for (int i = 1; i < 12; i++) begin
      applyStimulus(0);
      checkOutput($sformatf("imp_%0d_p0", i), 2 * i + 1);
      checkOutput($sformatf("imp_%0d_p1", i), 2 * i + 2);
    end
    applyStimulus(0);
    checkOutput("imp_tail_p0", 0);
    checkOutput("imp_tail_p1", 0);

    $display("[TB] writes while enabled are ignored");
    for (int i = 0; i < 4; i++) write_coeff(i, 32'h7FFF);
    restart_filter();
    applyStimulus(32767);
    checkOutput("wprot_p0", 1);
    checkOutput("wprot_p1", 2);
    applyStimulus(0);
    checkOutput("wprot_p2", 3);
    checkOutput("wprot_p3", 4);

    $display("[TB] backpressure 48 taps x4");
    mode_tfir   = 2'b10;
    interp_tfir = 2'b10;
    restart_filter();
    applyStimulus(32767);
    io.out_ready = 1'b0;
    wait_valid("bp_first");
    io.in       = 16'sd555;
    io.in_valid = 1'b1;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_m);
      if (io.out !== 16'sd1 || io.out_valid !== 1'b1 || io.in_ready !== 1'b0) stable = 0;
    end
    check("bp_stable", stable, 1);
    check("bp_in_ready", 32'(io.in_ready), 0);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    check("bp_p0", 32'(io.out), 1);
    @(posedge clk_m);
    #1;
    checkOutput("bp_p1", 2);
    checkOutput("bp_p2", 3);
    checkOutput("bp_p3", 4);
    applyStimulus(0);
    checkOutput("bp_n1_p0", 5);
    checkOutput("bp_n1_p1", 6);
    checkOutput("bp_n1_p2", 7);
    checkOutput("bp_n1_p3", 8);

    $display("[TB] reset during MAC");
    applyStimulus(32767);
    @(negedge clk_m);
    @(negedge clk_m);
    reset = 1'b1;
    @(negedge clk_m);
    check("rmac_out", 32'(io.out), 0);
    check("rmac_out_valid", 32'(io.out_valid), 0);
    check("rmac_in_ready", 32'(io.in_ready), 0);
    reset       = 1'b0;
    mode_tfir   = 2'b01;
    interp_tfir = 2'b01;
    applyStimulus(32767);
    checkOutput("rmac_imp_p0", 1);
    checkOutput("rmac_imp_p1", 2);
    applyStimulus(0);
    checkOutput("rmac_imp_p2", 3);
    checkOutput("rmac_imp_p3", 4);

    $display("[TB] interp change mid-sample");
    restart_filter();
    applyStimulus(32767);
    io.out_ready = 1'b0;
    wait_valid("cc_p0");
    interp_tfir  = 2'b10;
    io.out_ready = 1'b1;
    check("cc_p0", 32'(io.out), 1);
    @(posedge clk_m);
    #1;
    checkOutput("cc_p1", 2);
    @(negedge clk_m);
    check("cc_idle_in_ready", 32'(io.in_ready), 1);
    applyStimulus(0);
    checkOutput("cc_x4_p0", 5);
    checkOutput("cc_x4_p1", 6);
    checkOutput("cc_x4_p2", 7);
    checkOutput("cc_x4_p3", 8);

    $display("[TB] saturation 24 taps x1 +6dB");
    @(negedge clk_m);
    en_tfir = 1'b0;
    for (int i = 0; i < 24; i++) write_coeff(i, 32'h7FFF);
    mode_tfir   = 2'b01;
    interp_tfir = 2'b00;
    gain_tfir   = 2'b01;
    @(negedge clk_m);
    en_tfir = 1'b1;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(32767);
      checkOutput($sformatf("sat_pos_%0d", i), 32767);
    end
    for (int i = 0; i < 23; i++) begin
      applyStimulus(-32768);
      drain_output($sformatf("sat_neg_%0d", i));
    end
    applyStimulus(-32768);
    checkOutput("sat_neg_steady", -32768);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adrv9009_tfir_interp.md
# adrv9009_tfir_interp

Transmit-side programmable FIR interpolator, the counterpart of the receive signal path's RFIR/decimator. It accepts 16-bit baseband samples at the low rate, interpolates by 1, 2 or 4 through a polyphase FIR with 24 or 48 programmable taps, and applies gain, rounding and saturation. Samples stream out toward the DAC/JESD side. Coefficients are loaded through the same address/data write port style the receive path uses. A single time-multiplexed MAC engine computes every output sample.

## Interface
- DW, 16, sample width (in/out)
- CW, 16, coefficient width, Q1.15
- MAX_TAPS, 48, coefficient RAM depth and history depth
- ADDR_W, 6, coefficient address width
- ACC_W, 40, accumulator width
- clk_m  input  1  sample/processing clock; the only clock
- reset  input  1  synchronous, active-high
- in  input  DW  signed input sample
- in_valid / in_ready  input / output  1  input handshake; transfer on clk_m edge with both high
- out  output  DW  signed output sample
- out_valid / out_ready  output / input  1  output handshake; out held stable while out_valid && !out_ready
- en_tfir  input  1  1 = filter active, 0 = bypass
- mode_tfir  input  2  01 = 24 taps, 10/00/11 = 48 taps
- interp_tfir  input  2  00 = x1, 01 = x2, 10/11 = x4
- gain_tfir  input  2  00 = 0 dB, 01 = +6 dB, 10 = −6 dB, 11 = −12 dB
- wr_en  input  1  coefficient write strobe
- addr_in  input  ADDR_W  coefficient index
- coeff_in  input  CW  coefficient value

## Operation
- Reset: out=0, out_valid=0, in_ready=0, FSM=IDLE, history cleared. Coefficient RAM is not cleared.
- Writes: accepted only when en_tfir=0 and addr_in<MAX_TAPS. Otherwise they are ignored.
- Bypass (en_tfir=0): in_ready = !out_valid || out_ready. An accepted sample is registered to out with out_valid=1 the next cycle, with no gain applied.
- Rising edge of en_tfir clears history; FSM enters IDLE.
- Filter (en_tfir=1). N=taps, L=interp factor, M=N/L (24 taps: M=24/12/6; 48 taps: M=48/24/12).
- FSM states and transitions:
  - IDLE: in_ready=1. On handshake, sample N, L and gain; shift in into history x[0]; set p=0; go to MAC.
  - MAC: for k=0..M-1 (one per cycle), acc += h[k·L+p]·x[k]; acc is cleared at k=0; after k=M-1 go to RND.
  - RND: y = sat16((acc + 2^(s−1)) >>> s), with s=15/14/16/17 for gain 00/01/10/11. Load out, set out_valid=1, go to OUT.
  - OUT: hold until out_ready. On handshake, if p<L−1 then p++ and go to MAC; else go to IDLE.
- Control changes mid-sample take effect at the next IDLE handshake.
- Products are full 32-bit signed. The accumulator is ACC_W signed, so no internal overflow. Saturation clamps to [−32768, 32767].

## Timing
- Input handshake at edge t: MAC occupies cycles t+1..t+M, RND at t+M+1, out_valid high from t+M+2.
- After an output handshake for p<L−1, the next MAC starts the following cycle. Each phase costs M+2 cycles plus backpressure.
- After the last phase, in_ready is high the cycle after the output handshake.
- in_ready is low in MAC/RND/OUT. A simultaneous in_valid is not consumed.
- Reset mid-computation: all outputs return to reset values at the next edge, and the partial result is discarded.

## Structure
- Package adrv9009_tx_pkg holds DW, CW, MAX_TAPS, ADDR_W, ACC_W, the mode/interp/gain encodings, the FSM state enum, and the gain-to-shift constants.
- Sub-module adrv9009_tfir_coeff_ram: MAX_TAPS×CW register array with synchronous write and asynchronous read. It takes the write gating from the parent.
- History, FSM, MAC and rounding/saturation live in the top module.

## Test plan
- Impulse, 24 taps, x2, 0 dB, h[i]=i+1: input 32767 then zeros -> outputs 1,2,3,…,24 then 0s; first out_valid 14 cycles after the accept edge.
- Saturation, 24 taps, x1, +6 dB, all h=0x7FFF, DC input 32767 -> 32767 in steady state; DC input −32768 -> −32768.
- Bypass, en_tfir=0: in=1234 -> out=1234, out_valid the next cycle. Writes during en_tfir=1 leave coefficients unchanged (verified by a repeated impulse).
- Backpressure, 48 taps, x4: out_ready low for 10 cycles in OUT -> out stable, in_ready=0, no samples lost or duplicated; 4 outputs per input.
- Reset asserted during MAC -> out=0, out_valid=0, in_ready=0 next cycle. After release, the impulse test reproduces the expected sequence with the retained coefficients.
- Control change mid-sample (interp x2→x4 during OUT of p=0) -> phase p=1 still completes under x2; x4 applies from the next input.
